// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and a post-reset zeroing sweep.
// Optional same-cycle write-through bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AWIDTH   = $clog2(NREG),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] rs1_id,
  input  logic [AWIDTH-1:0] rs2_id,
  output logic [DWIDTH-1:0] rs1,
  output logic [DWIDTH-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              we,
  input  logic [AWIDTH-1:0] rdst_id,
  input  logic [DWIDTH-1:0] rdst,
  input  logic              alloc,
  input  logic [AWIDTH-1:0] alloc_id,
  output logic              ready
);

  localparam int unsigned NID = 1 << AWIDTH;

  typedef enum logic {INIT, RUN} state_t;

  // Per-ID usability: in range and not the hardwired zero register.
  function automatic logic [NID-1:0] id_mask();
    logic [NID-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NID; i++) begin
      m[i] = (i < NREG) && !((ZERO_REG != 0) && (i == 0));
    end
    return m;
  endfunction

  localparam logic [NID-1:0] ID_OK = id_mask();

  state_t              state;
  state_t              state_nxt;
  logic [AWIDTH-1:0]   init_ptr;
  logic [AWIDTH-1:0]   init_ptr_nxt;
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [DWIDTH-1:0]   mem_wdata;
  logic                wr_run;
  logic                alloc_run;
  logic [DWIDTH-1:0]   mem [NREG];
  logic [NREG-1:0]     busy;

  // Next-state and single shared storage write port (sweep or writeback).
  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    mem_we       = 1'b0;
    mem_waddr    = rdst_id;
    mem_wdata    = rdst;
    wr_run       = 1'b0;
    alloc_run    = 1'b0;
    case (state)
      INIT: begin
        mem_we       = 1'b1;
        mem_waddr    = init_ptr;
        mem_wdata    = '0;
        init_ptr_nxt = init_ptr + AWIDTH'(1);
        if (init_ptr == AWIDTH'(NREG - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        wr_run    = we && ID_OK[rdst_id];
        alloc_run = alloc && ID_OK[alloc_id];
        mem_we    = wr_run;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
      ready    <= (state_nxt == RUN);
    end
  end

  // Storage has no reset; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Alloc is applied last so a same-ID alloc wins over the writeback clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_run) begin
        busy[rdst_id] <= 1'b0;
      end
      if (alloc_run) begin
        busy[alloc_id] <= 1'b1;
      end
    end
  end

  always_comb begin
    rs1      = '0;
    rs2      = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (state == RUN) begin
      if (ID_OK[rs1_id]) begin
        rs1      = mem[rs1_id];
        rs1_busy = busy[rs1_id];
      end
      if (ID_OK[rs2_id]) begin
        rs2      = mem[rs2_id];
        rs2_busy = busy[rs2_id];
      end
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_run && (rdst_id == rs1_id)) begin
      rs1      = rdst;
      rs1_busy = 1'b0;
    end
    if (wr_run && (rdst_id == rs2_id)) begin
      rs2      = rdst;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (NREG=32 zero-reg, NREG=20 plain) against an array model.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0][AW-1:0] rs1_id, rs2_id, rdst_id, alloc_id;
  logic [1:0][DW-1:0] rdst, rs1, rs2;
  logic [1:0]         we, alloc, rs1_busy, rs2_busy, ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_mem  [2][32];
  logic          m_busy [2][32];
  int            m_cnt  [2];
  bit            model_live = 1'b0;

  always #5 clk = ~clk;

  reg_file_sb #(.DWIDTH(32), .NREG(32), .ZERO_REG(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id[0]), .rs2_id(rs2_id[0]), .rs1(rs1[0]), .rs2(rs2[0]),
    .rs1_busy(rs1_busy[0]), .rs2_busy(rs2_busy[0]),
    .we(we[0]), .rdst_id(rdst_id[0]), .rdst(rdst[0]),
    .alloc(alloc[0]), .alloc_id(alloc_id[0]), .ready(ready[0])
  );

  reg_file_sb #(.DWIDTH(32), .NREG(20), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id[1]), .rs2_id(rs2_id[1]), .rs1(rs1[1]), .rs2(rs2[1]),
    .rs1_busy(rs1_busy[1]), .rs2_busy(rs2_busy[1]),
    .we(we[1]), .rdst_id(rdst_id[1]), .rdst(rdst[1]),
    .alloc(alloc[1]), .alloc_id(alloc_id[1]), .ready(ready[1])
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nreg_of(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  function automatic bit usable(input int k, input int id);
    return (id < nreg_of(k)) && !((k == 0) && (id == 0));
  endfunction

  function automatic bit m_ready(input int k);
    return m_cnt[k] >= nreg_of(k);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k, input int id);
    if (!m_ready(k) || !usable(k, id)) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we[k] && (int'(rdst_id[k]) == id)) return rdst[k];
`endif
    return m_mem[k][id];
  endfunction

  function automatic logic exp_busy(input int k, input int id);
    if (!m_ready(k) || !usable(k, id)) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (we[k] && (int'(rdst_id[k]) == id)) return 1'b0;
`endif
    return m_busy[k][id];
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.ready", k), DW'(ready[k]), DW'(m_ready(k)));
      check($sformatf("u%0d.rs1", k), rs1[k], exp_data(k, int'(rs1_id[k])));
      check($sformatf("u%0d.rs2", k), rs2[k], exp_data(k, int'(rs2_id[k])));
      check($sformatf("u%0d.rs1_busy", k), DW'(rs1_busy[k]), DW'(exp_busy(k, int'(rs1_id[k]))));
      check($sformatf("u%0d.rs2_busy", k), DW'(rs2_busy[k]), DW'(exp_busy(k, int'(rs2_id[k]))));
    end
  endtask

  // Model step: a reset makes every register read as zero once the sweep is done.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0;
        for (int i = 0; i < 32; i++) begin
          m_mem[k][i]  = '0;
          m_busy[k][i] = 1'b0;
        end
      end else if (!m_ready(k)) begin
        m_cnt[k]++;
      end else begin
        if (we[k] && usable(k, int'(rdst_id[k]))) begin
          m_mem[k][rdst_id[k]]  = rdst[k];
          m_busy[k][rdst_id[k]] = 1'b0;
        end
        if (alloc[k] && usable(k, int'(alloc_id[k]))) begin
          m_busy[k][alloc_id[k]] = 1'b1;
        end
      end
    end
    model_live = 1'b1;
  endtask

  task automatic tick();
    #1;
    if (model_live) check_all();
    @(posedge clk);
    model_edge();
    #1;
    we    = '0;
    alloc = '0;
  endtask

  task automatic do_we(input int k, input int id, input logic [DW-1:0] d);
    we[k] = 1'b1; rdst_id[k] = AW'(id); rdst[k] = d;
  endtask

  task automatic do_alloc(input int k, input int id);
    alloc[k] = 1'b1; alloc_id[k] = AW'(id);
  endtask

  task automatic set_rd(input int k, input int a, input int b);
    rs1_id[k] = AW'(a); rs2_id[k] = AW'(b);
  endtask

  initial begin
    rst_n = 1'b0;
    we = '0; alloc = '0; rdst = '0; rdst_id = '0; alloc_id = '0;
    rs1_id = '0; rs2_id = '0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    set_rd(0, 1, 31);
    set_rd(1, 19, 0);
    repeat (32) tick();
    #1;
    check("ready_after_32", DW'(ready[0]), DW'(1));

    do_we(0, 5, 32'hDEADBEEF);
    tick();
    set_rd(0, 5, 0);
    #1;
    check("r5_read", rs1[0], 32'hDEADBEEF);
    do_we(0, 0, 32'h1234);
    tick();
    #1;
    check("r0_zero", rs2[0], 32'h0);

    do_alloc(0, 7);
    tick();
    set_rd(0, 7, 5);
    #1;
    check("r7_busy", DW'(rs1_busy[0]), DW'(1));
    do_we(0, 7, 32'hA5);
`ifdef REG_FILE_BYPASS_EN
    #1;
    check("r7_bypass_data", rs1[0], 32'hA5);
    check("r7_bypass_busy", DW'(rs1_busy[0]), DW'(0));
`endif
    tick();
    #1;
    check("r7_data", rs1[0], 32'hA5);
    check("r7_clear", DW'(rs1_busy[0]), DW'(0));

    do_alloc(0, 9);
    do_we(0, 9, 32'h55);
    tick();
    set_rd(0, 9, 7);
    #1;
    check("r9_data", rs1[0], 32'h55);
    check("r9_busy", DW'(rs1_busy[0]), DW'(1));

    do_we(1, 19, 32'h1919);
    tick();
    do_we(1, 25, 32'hBAD);
    do_alloc(1, 25);
    tick();
    set_rd(1, 25, 19);
    #1;
    check("oor_data", rs1[1], 32'h0);
    check("oor_busy", DW'(rs1_busy[1]), DW'(0));
    check("r19_data", rs2[1], 32'h1919);

    do_we(0, 3, 32'h77);
    do_alloc(0, 4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_rd(0, 3, 4);
    repeat (32) tick();
    #1;
    check("r3_after_reset", rs1[0], 32'h0);
    check("r4_busy_after_reset", DW'(rs2_busy[0]), DW'(0));

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < 2; k++) begin
        we[k]       = $urandom_range(0, 1) != 0;
        alloc[k]    = $urandom_range(0, 2) == 0;
        rdst_id[k]  = AW'($urandom_range(0, 31));
        alloc_id[k] = ($urandom_range(0, 3) == 0) ? rdst_id[k] : AW'($urandom_range(0, 31));
        rdst[k]     = $urandom;
        rs1_id[k]   = ($urandom_range(0, 2) == 0) ? rdst_id[k] : AW'($urandom_range(0, 31));
        rs2_id[k]   = ($urandom_range(0, 2) == 0) ? alloc_id[k] : AW'($urandom_range(0, 31));
      end
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
